pong_game_engine: RTL and testbench



---
 rtl/pong_game_engine.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_pong_game_engine.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_engine.sv
// pong_game_engine: complete two-player pong game state.
// Owns both pad controllers, ball motion with wall and pad collisions,
// per-player scoring and the IDLE/SERVE/PLAY/POINT/OVER game FSM.
// Everything except the POINT resolution advances only on timing_tick.
// Optional build macro: PONG_AI_PLAYER_2_EN -- when defined, the right pad
// tracks the ball automatically and up_2/down_2 are ignored.
// Parameter constraint: WIN_SCORE < 2**SCORE_W.
module pong_game_engine #(
  parameter int SCREEN_W    = 1024,
  parameter int SCREEN_H    = 768,
  parameter int BALL_SIZE   = 16,
  parameter int PAD_W       = 16,
  parameter int PAD_H       = 96,
  parameter int PAD_X_LEFT  = 32,
  parameter int PAD_X_RIGHT = 976,
  parameter int BALL_SPEED  = 4,
  parameter int PAD_SPEED   = 8,
  parameter int SERVE_DELAY = 60,
  parameter int WIN_SCORE   = 7,
  parameter int SCORE_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               timing_tick,
  input  logic               start,
  input  logic               up_1,
  input  logic               down_1,
  input  logic               up_2,
  input  logic               down_2,
  output logic [10:0]        x_ball,
  output logic [9:0]         y_ball,
  output logic [9:0]         y_player_1,
  output logic [9:0]         y_player_2,
  output logic [SCORE_W-1:0] score_1,
  output logic [SCORE_W-1:0] score_2,
  output logic [2:0]         game_state,
  output logic [1:0]         winner
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  // Signed working type for ball arithmetic so that moves past the top
  // wall show up as negative values instead of wrapping.
  typedef logic signed [12:0] coord_t;

  localparam int CNT_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;

  localparam logic [10:0] X_CENTRE    = 11'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [9:0]  Y_CENTRE    = 10'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [9:0]  PAD_Y_RESET = 10'((SCREEN_H - PAD_H) / 2);
  localparam logic [10:0] PAD_Y_MAX   = 11'(SCREEN_H - PAD_H);
  localparam logic [10:0] PAD_STEP    = 11'(PAD_SPEED);

  localparam coord_t BALL_STEP    = coord_t'(BALL_SPEED);
  localparam coord_t BALL_SZ      = coord_t'(BALL_SIZE);
  localparam coord_t PAD_HT       = coord_t'(PAD_H);
  localparam coord_t BALL_Y_MAX   = coord_t'(SCREEN_H - BALL_SIZE);
  localparam coord_t LEFT_FACE    = coord_t'(PAD_X_LEFT + PAD_W);
  localparam coord_t RIGHT_FACE   = coord_t'(PAD_X_RIGHT);
  localparam coord_t RIGHT_STOP   = coord_t'(PAD_X_RIGHT - BALL_SIZE);
  localparam coord_t MISS_X_RIGHT = coord_t'(SCREEN_W - BALL_SIZE - BALL_SPEED);

  localparam logic [SCORE_W-1:0] SCORE_WIN = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  state_t             state_q, state_d;
  logic [10:0]        x_q, x_d;
  logic [9:0]         y_q, y_d;
  logic               dx_q, dx_d;        // 1: moving toward P2 (right)
  logic               dy_q, dy_d;        // 1: moving down
  logic [9:0]         pad_1_q, pad_1_d;
  logic [9:0]         pad_2_q, pad_2_d;
  logic [SCORE_W-1:0] score_1_q, score_1_d;
  logic [SCORE_W-1:0] score_2_q, score_2_d;
  logic [1:0]         winner_q, winner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               scorer_p2_q, scorer_p2_d;  // 1: P2 won the rally

  logic               up_2_eff, down_2_eff;
  coord_t             x_s, y_s, nx, ny, pad_1_s, pad_2_s;
  logic               overlap_1, overlap_2, hit_left, hit_right;
  logic [SCORE_W-1:0] score_1_inc, score_2_inc;

  // One pad step: signed-free 11-bit arithmetic, clamped to the playfield.
  function automatic logic [9:0] pad_step(input logic [9:0] y,
                                          input logic       up,
                                          input logic       down);
    logic [10:0] y_ext;
    y_ext    = {1'b0, y};
    pad_step = y;
    if (up && !down) begin
      if (y_ext < PAD_STEP) pad_step = '0;
      else                  pad_step = 10'(y_ext - PAD_STEP);
    end else if (down && !up) begin
      if (y_ext + PAD_STEP > PAD_Y_MAX) pad_step = 10'(PAD_Y_MAX);
      else                              pad_step = 10'(y_ext + PAD_STEP);
    end
  endfunction

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    sat_inc = (s == SCORE_MAX) ? s : s + 1'b1;
  endfunction

`ifdef PONG_AI_PLAYER_2_EN
  logic [11:0] pad_2_centre, ball_centre;
  logic        manual_2_unused;

  // AI pad: chase the ball centre, with a PAD_SPEED dead band to avoid jitter.
  always_comb begin
    pad_2_centre    = 12'(pad_2_q) + 12'(PAD_H / 2);
    ball_centre     = 12'(y_q) + 12'(BALL_SIZE / 2);
    up_2_eff        = pad_2_centre > ball_centre + 12'(PAD_SPEED);
    down_2_eff      = pad_2_centre + 12'(PAD_SPEED) < ball_centre;
    manual_2_unused = up_2 ^ down_2;
  end
`else
  // Manual right pad straight from the player 2 controls.
  always_comb begin
    up_2_eff   = up_2;
    down_2_eff = down_2;
  end
`endif

  // Candidate ball move and collision predicates, all from current state.
  always_comb begin
    x_s       = coord_t'({2'b00, x_q});
    y_s       = coord_t'({3'b000, y_q});
    pad_1_s   = coord_t'({3'b000, pad_1_q});
    pad_2_s   = coord_t'({3'b000, pad_2_q});
    nx        = dx_q ? x_s + BALL_STEP : x_s - BALL_STEP;
    ny        = dy_q ? y_s + BALL_STEP : y_s - BALL_STEP;
    overlap_1 = (y_s + BALL_SZ > pad_1_s) && (y_s < pad_1_s + PAD_HT);
    overlap_2 = (y_s + BALL_SZ > pad_2_s) && (y_s < pad_2_s + PAD_HT);
    hit_left  = !dx_q && (x_s >= LEFT_FACE) && (nx <= LEFT_FACE) && overlap_1;
    hit_right = dx_q && (x_s + BALL_SZ <= RIGHT_FACE) &&
                (nx + BALL_SZ >= RIGHT_FACE) && overlap_2;
    score_1_inc = sat_inc(score_1_q);
    score_2_inc = sat_inc(score_2_q);
  end

  // Next-state logic for the FSM, ball, pads and scores.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    pad_1_d     = pad_1_q;
    pad_2_d     = pad_2_q;
    score_1_d   = score_1_q;
    score_2_d   = score_2_q;
    winner_d    = winner_q;
    cnt_d       = cnt_q;
    scorer_p2_d = scorer_p2_q;

    if (timing_tick && (state_q != ST_OVER)) begin
      pad_1_d = pad_step(pad_1_q, up_1, down_1);
      pad_2_d = pad_step(pad_2_q, up_2_eff, down_2_eff);
    end

    case (state_q)
      ST_IDLE: begin
        x_d = X_CENTRE;
        y_d = Y_CENTRE;
        if (timing_tick && start) begin
          state_d = ST_SERVE;
          cnt_d   = '0;
        end
      end

      ST_SERVE: begin
        x_d = X_CENTRE;
        y_d = Y_CENTRE;
        if (timing_tick) begin
          if (cnt_q == CNT_W'(SERVE_DELAY - 1)) state_d = ST_PLAY;
          else                                  cnt_d   = cnt_q + 1'b1;
        end
      end

      ST_PLAY: begin
        if (timing_tick) begin
          if (!dx_q && (x_s < BALL_STEP)) begin
            state_d     = ST_POINT;
            scorer_p2_d = 1'b1;
          end else if (dx_q && (x_s > MISS_X_RIGHT)) begin
            state_d     = ST_POINT;
            scorer_p2_d = 1'b0;
          end else begin
            // Vertical axis: walls.
            if (ny < 0) begin
              y_d  = '0;
              dy_d = 1'b1;
            end else if (ny > BALL_Y_MAX) begin
              y_d  = 10'(BALL_Y_MAX);
              dy_d = 1'b0;
            end else begin
              y_d = 10'(ny);
            end
            // Horizontal axis: pads, independent of the wall decision.
            if (hit_left) begin
              x_d  = 11'(LEFT_FACE);
              dx_d = 1'b1;
            end else if (hit_right) begin
              x_d  = 11'(RIGHT_STOP);
              dx_d = 1'b0;
            end else begin
              x_d = 11'(nx);
            end
          end
        end
      end

      // Resolves in a single clk without waiting for a tick.
      ST_POINT: begin
        if (scorer_p2_q) begin
          score_2_d = score_2_inc;
          if (score_2_inc == SCORE_WIN) begin
            state_d  = ST_OVER;
            winner_d = 2'd2;
          end else begin
            state_d = ST_SERVE;
            x_d     = X_CENTRE;
            y_d     = Y_CENTRE;
            dx_d    = 1'b0;          // serve toward P1, who conceded
            cnt_d   = '0;
          end
        end else begin
          score_1_d = score_1_inc;
          if (score_1_inc == SCORE_WIN) begin
            state_d  = ST_OVER;
            winner_d = 2'd1;
          end else begin
            state_d = ST_SERVE;
            x_d     = X_CENTRE;
            y_d     = Y_CENTRE;
            dx_d    = 1'b1;          // serve toward P2, who conceded
            cnt_d   = '0;
          end
        end
      end

      ST_OVER: begin
        if (timing_tick && start) begin
          state_d   = ST_SERVE;
          score_1_d = '0;
          score_2_d = '0;
          winner_d  = 2'd0;
          x_d       = X_CENTRE;
          y_d       = Y_CENTRE;
          dx_d      = 1'b1;
          cnt_d     = '0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= ST_IDLE;
      x_q         <= X_CENTRE;
      y_q         <= Y_CENTRE;
      dx_q        <= 1'b1;
      dy_q        <= 1'b1;
      pad_1_q     <= PAD_Y_RESET;
      pad_2_q     <= PAD_Y_RESET;
      score_1_q   <= '0;
      score_2_q   <= '0;
      winner_q    <= 2'd0;
      cnt_q       <= '0;
      scorer_p2_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      pad_1_q     <= pad_1_d;
      pad_2_q     <= pad_2_d;
      score_1_q   <= score_1_d;
      score_2_q   <= score_2_d;
      winner_q    <= winner_d;
      cnt_q       <= cnt_d;
      scorer_p2_q <= scorer_p2_d;
    end
  end

  assign x_ball     = x_q;
  assign y_ball     = y_q;
  assign y_player_1 = pad_1_q;
  assign y_player_2 = pad_2_q;
  assign score_1    = score_1_q;
  assign score_2    = score_2_q;
  assign game_state = state_q;
  assign winner     = winner_q;

endmodule

// File: tb/tb_pong_game_engine.sv
// tb_pong_game_engine: directed bench for pong_game_engine (default build,
// manual right pad) with SERVE_DELAY=3 and WIN_SCORE=2.
module tb_pong_game_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        timing_tick;
  logic        start;
  logic        up_1, down_1, up_2, down_2;
  logic [10:0] x_ball;
  logic [9:0]  y_ball, y_player_1, y_player_2;
  logic [3:0]  score_1, score_2;
  logic [2:0]  game_state;
  logic [1:0]  winner;

  int n_checks = 0;
  int n_fail   = 0;

  pong_game_engine #(
    .SERVE_DELAY (3),
    .WIN_SCORE   (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .timing_tick (timing_tick),
    .start       (start),
    .up_1        (up_1),
    .down_1      (down_1),
    .up_2        (up_2),
    .down_2      (down_2),
    .x_ball      (x_ball),
    .y_ball      (y_ball),
    .y_player_1  (y_player_1),
    .y_player_2  (y_player_2),
    .score_1     (score_1),
    .score_2     (score_2),
    .game_state  (game_state),
    .winner      (winner)
  );

  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_ball(input string name, input int ex, input int ey);
    check({name, ".x"}, 32'(x_ball), ex);
    check({name, ".y"}, 32'(y_ball), ey);
  endtask

  // One tick: tick high across exactly one posedge; returns at the
  // following negedge where outputs are sampled.
  task automatic do_tick();
    @(negedge clk);
    timing_tick = 1'b1;
    @(negedge clk);
    timing_tick = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  typedef struct {
    logic u1, d1, u2, d2;
    int   ticks;
    int   exp_p1, exp_p2;
  } pad_vec_t;

  pad_vec_t vecs[11];

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 41, 8,   336};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1,  0,   336};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8,  0,   336};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 84, 672, 336};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 6,  672, 336};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3,  672, 336};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1,  664, 336};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3,  664, 360};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3,  664, 336};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4,  664, 336};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 42, 672, 672};

    rst = 1'b1; timing_tick = 1'b0; start = 1'b1;
    up_1 = 1'b0; down_1 = 1'b0; up_2 = 1'b0; down_2 = 1'b0;

    // Reset held with start asserted and ticks arriving.
    run_ticks(3);
    check("rst.state", 32'(game_state), 0);
    check_ball("rst.ball", 504, 376);
    check("rst.pad1", 32'(y_player_1), 336);
    check("rst.pad2", 32'(y_player_2), 336);
    check("rst.score1", 32'(score_1), 0);
    check("rst.score2", 32'(score_2), 0);
    check("rst.winner", 32'(winner), 0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;

    // Pads ignore inputs between ticks.
    up_1 = 1'b1;
    repeat (5) @(negedge clk);
    check("pad.no_tick", 32'(y_player_1), 336);
    up_1 = 1'b0;

    // Table-driven pad movement in IDLE.
    for (int v = 0; v < 11; v++) begin
      up_1 = vecs[v].u1; down_1 = vecs[v].d1;
      up_2 = vecs[v].u2; down_2 = vecs[v].d2;
      run_ticks(vecs[v].ticks);
      check($sformatf("vec%0d.pad1", v), 32'(y_player_1), 32'(vecs[v].exp_p1));
      check($sformatf("vec%0d.pad2", v), 32'(y_player_2), 32'(vecs[v].exp_p2));
      check($sformatf("vec%0d.state", v), 32'(game_state), 0);
    end
    up_1 = 1'b0; down_1 = 1'b0; up_2 = 1'b0; down_2 = 1'b0;
    check_ball("idle.ball", 504, 376);

    // Start and serve delay: three ticks in SERVE, then PLAY.
    start = 1'b1;
    do_tick();
    start = 1'b0;
    check("serve.enter", 32'(game_state), 1);
    run_ticks(2);
    check("serve.t2", 32'(game_state), 1);
    check_ball("serve.t2.ball", 504, 376);
    do_tick();
    check("serve.t3", 32'(game_state), 2);
    check_ball("serve.t3.ball", 504, 376);

    // Game A: down-right, bottom wall, right pad at 672 returns the ball.
    do_tick();
    check_ball("a.t1", 508, 380);
    run_ticks(93);
    check_ball("a.t94", 880, 752);
    do_tick();
    check_ball("a.t95", 884, 752);
    do_tick();
    check_ball("a.t96", 888, 748);
    run_ticks(18);
    check_ball("a.t114.pad_hit", 960, 676);
    do_tick();
    check_ball("a.t115", 956, 672);
    up_2 = 1'b1;
    run_ticks(84);
    up_2 = 1'b0;
    check("a.pad2_top", 32'(y_player_2), 0);
    check_ball("a.t199", 620, 336);
    start = 1'b1;
    do_tick();
    start = 1'b0;
    check("a.start_ignored", 32'(game_state), 2);
    run_ticks(155);
    check("a.point", 32'(game_state), 3);
    check_ball("a.miss_hold", 0, 280);
    check("a.point.score2", 32'(score_2), 0);
    @(negedge clk);
    check("a.reserve", 32'(game_state), 1);
    check("a.score2", 32'(score_2), 1);
    check("a.score1", 32'(score_1), 0);
    check_ball("a.recentre", 504, 376);

    // Game B: serve toward P1; left pad returns, right pad at 0 misses.
    run_ticks(3);
    check("b.play", 32'(game_state), 2);
    do_tick();
    check_ball("b.t1", 500, 380);
    run_ticks(113);
    check_ball("b.t114.pad_hit", 48, 676);
    run_ticks(241);
    check("b.point", 32'(game_state), 3);
    check_ball("b.miss_hold", 1008, 280);
    @(negedge clk);
    check("b.reserve", 32'(game_state), 1);
    check("b.score1", 32'(score_1), 1);
    check("b.score2", 32'(score_2), 1);
    check("b.winner", 32'(winner), 0);

    // Game C: P1 scores again and wins.
    run_ticks(3);
    do_tick();
    check_ball("c.t1", 508, 380);
    run_ticks(125);
    check_ball("c.t126", 1008, 628);
    do_tick();
    check("c.point", 32'(game_state), 3);
    @(negedge clk);
    check("c.over", 32'(game_state), 4);
    check("c.winner", 32'(winner), 1);
    check("c.score1", 32'(score_1), 2);

    // OVER freezes everything across ticks even with controls pressed.
    up_1 = 1'b1; down_2 = 1'b1;
    run_ticks(10);
    up_1 = 1'b0; down_2 = 1'b0;
    check("over.state", 32'(game_state), 4);
    check_ball("over.ball", 1008, 628);
    check("over.pad1", 32'(y_player_1), 672);
    check("over.pad2", 32'(y_player_2), 0);
    check("over.score1", 32'(score_1), 2);
    check("over.score2", 32'(score_2), 1);

    // Restart from OVER.
    start = 1'b1;
    do_tick();
    start = 1'b0;
    check("restart.state", 32'(game_state), 1);
    check("restart.score1", 32'(score_1), 0);
    check("restart.score2", 32'(score_2), 0);
    check("restart.winner", 32'(winner), 0);
    check_ball("restart.ball", 504, 376);
    run_ticks(4);
    check_ball("restart.t1", 508, 372);

    // Reset mid-PLAY restores everything on the next clk.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst.state", 32'(game_state), 0);
    check_ball("midrst.ball", 504, 376);
    check("midrst.pad1", 32'(y_player_1), 336);
    check("midrst.pad2", 32'(y_player_2), 336);
    rst = 1'b0;
    start = 1'b1;
    do_tick();
    start = 1'b0;
    run_ticks(4);
    check_ball("midrst.t1", 508, 380);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
